// File: rtl/lsu_pkg.sv
// +------------------------------------------------------------------+
// | lsu_pkg                                                          |
// | Shared size encodings, FSM states and defaults for the LSU.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  localparam int LSU_ADDR_W = 10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_DATA = 3'd2,
    ST_WR   = 3'd3,
    ST_RSP  = 3'd4
  } state_t;

  // Reserved size (2'b11) is checked like a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lane[0];
      default: mis = |lane;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// +------------------------------------------------------------------+
// | lsu_align                                                        |
// | Combinational lane extract/extend for loads and merge for stores.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte   = rd_word[{lane, 3'b000} +: 8];
    sel_half   = rd_word[{lane[1], 4'b0000} +: 16];
    load_data  = rd_word;
    store_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
        store_data = rd_word;
        store_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{~is_unsigned & sel_half[15]}}, sel_half};
        store_data = rd_word;
        store_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rd_word;
        store_data = wdata;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +------------------------------------------------------------------+
// | load_store_unit                                                  |
// | Valid/ready load/store initiator for a word-addressed data RAM.  |
// | Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          lane_q, lane_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [ADDR_W-1:0]   word_addr;
  logic                misalign;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   store_data;
  logic                unused_addr_bits;

  // Byte address bits above the RAM range wrap silently.
  assign word_addr        = req_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(req_size, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  lsu_align u_align (
    .rd_word     (mem_rdata),
    .wdata       (wdata_q),
    .size        (size_q),
    .lane        (lane_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          size_d      = req_size;
          uns_d       = req_unsigned;
          lane_d      = req_addr[1:0];
          wdata_d     = req_wdata;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (misalign) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = ST_RSP;
          end else if (req_we && req_size[1]) begin
            // Full-word store needs no read; write straight away.
            mem_we_d    = 1'b1;
            mem_addr_d  = word_addr;
            mem_wdata_d = req_wdata;
            state_d     = ST_WR;
          end else begin
            mem_addr_d  = word_addr;
            state_d     = ST_RD;
          end
        end
      end
      ST_RD: state_d = ST_DATA;
      ST_DATA: begin
        if (we_q) begin
          mem_wdata_d = store_data;
          mem_we_d    = 1'b1;
          state_d     = ST_WR;
        end else begin
          rsp_rdata_d = load_data;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_WR: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a RAM and an array-based reference model.
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram     [1024];
  logic [31:0] ref_mem [1024];

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] last_rdata;

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit model_misaligned(input int size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 1) return addr[0];
    if (size >= 2) return addr[1:0] != 2'b00;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input int size, input bit uns,
                                             input logic [31:0] addr);
    logic [31:0] v;
    if (size == 0) begin
      v = (w >> (8 * addr[1:0])) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (w >> (16 * addr[1])) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input int size, input logic [31:0] addr);
    logic [31:0] mask;
    int          sh;
    if (size >= 2) return wd;
    if (size == 0) begin
      sh   = 8 * addr[1:0];
      mask = 32'hFF << sh;
    end else begin
      sh   = 16 * addr[1];
      mask = 32'hFFFF << sh;
    end
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // Issues one request and checks latency, RAM traffic and response against the model.
  task automatic do_req(input bit we, input int size, input bit uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
    int          wa, exp_lat, exp_we_cyc, we_cnt, we_cyc, rsp_cnt, rsp_cyc, guard;
    bit          mis, ready_busy, rd_addr_ok;
    logic [31:0] exp_rdata, exp_wdata, got_rdata, got_err, got_waddr, got_wdata;
    wa         = int'(addr[11:2]);
    mis        = model_misaligned(size, addr);
    exp_rdata  = 32'h0;
    exp_wdata  = 32'h0;
    exp_we_cyc = 0;
    if (mis) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat   = 3;
      exp_rdata = model_load(ref_mem[wa], size, uns, addr);
    end else if (size >= 2) begin
      exp_lat     = 2;
      exp_we_cyc  = 1;
      exp_wdata   = wdata;
      ref_mem[wa] = exp_wdata;
    end else begin
      exp_lat     = 4;
      exp_we_cyc  = 3;
      exp_wdata   = model_store(ref_mem[wa], wdata, size, addr);
      ref_mem[wa] = exp_wdata;
    end

    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = 2'(size);
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;

    we_cnt = 0; we_cyc = 0; rsp_cnt = 0; rsp_cyc = 0;
    ready_busy = 1'b0; rd_addr_ok = 1'b1;
    got_rdata = 32'hX; got_err = 32'hX; got_waddr = 32'hX; got_wdata = 32'hX;
    for (int k = 1; k <= 10; k++) begin
      if (k == 1 && !mis && exp_we_cyc != 1 && mem_addr !== 10'(wa)) rd_addr_ok = 1'b0;
      if (mem_we) begin
        we_cnt++;
        we_cyc    = k;
        got_waddr = 32'(mem_addr);
        got_wdata = mem_wdata;
      end
      if (rsp_cnt == 0 && req_ready) ready_busy = 1'b1;
      if (rsp_valid) begin
        if (rsp_cnt == 0) begin
          rsp_cyc   = k;
          got_rdata = rsp_rdata;
          got_err   = 32'(rsp_err);
        end
        rsp_cnt++;
      end
      @(posedge clk);
      #1;
    end
    last_rdata = got_rdata;

    chk({tag, ".lat"}, 32'(rsp_cyc), 32'(exp_lat));
    chk({tag, ".rsp_cnt"}, 32'(rsp_cnt), 32'd1);
    chk({tag, ".rdata"}, got_rdata, exp_rdata);
    chk({tag, ".err"}, got_err, 32'(mis));
    chk({tag, ".ready_busy"}, 32'(ready_busy), 32'd0);
    chk({tag, ".rd_addr"}, 32'(rd_addr_ok), 32'd1);
    chk({tag, ".we_cnt"}, 32'(we_cnt), (exp_we_cyc != 0) ? 32'd1 : 32'd0);
    if (exp_we_cyc != 0) begin
      chk({tag, ".we_cyc"}, 32'(we_cyc), 32'(exp_we_cyc));
      chk({tag, ".waddr"}, got_waddr, 32'(wa));
      chk({tag, ".wdata"}, got_wdata, exp_wdata);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rsp1, rsp2, mon_we, mon_rsp;
    logic [7:0]  ready_vec;
    logic [31:0] addr, saved;

    for (int i = 0; i < 1024; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    #12;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b1, 2, 1'b0, 32'h010, 32'hDEADBEEF, "wst");
    do_req(1'b0, 2, 1'b0, 32'h010, 32'h0, "wld");
    chk("wld.const", last_rdata, 32'hDEADBEEF);

    @(negedge clk);
    ram[4] = 32'h11223344; ref_mem[4] = 32'h11223344;
    do_req(1'b1, 0, 1'b0, 32'h012, 32'h000000AA, "bst");
    chk("bst.ram", ram[4], 32'h11AA3344);

    @(negedge clk);
    ram[4] = 32'h8081F0FF; ref_mem[4] = 32'h8081F0FF;
    do_req(1'b0, 0, 1'b0, 32'h013, 32'h0, "lb");
    chk("lb.const", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 0, 1'b1, 32'h013, 32'h0, "lbu");
    chk("lbu.const", last_rdata, 32'h00000080);
    do_req(1'b0, 1, 1'b0, 32'h010, 32'h0, "lh");
    chk("lh.const", last_rdata, 32'hFFFFF0FF);
    do_req(1'b0, 1, 1'b1, 32'h012, 32'h0, "lhu");
    chk("lhu.const", last_rdata, 32'h00008081);
    do_req(1'b0, 2, 1'b0, 32'h00001010, 32'h0, "wrap");
    chk("wrap.const", last_rdata, 32'h8081F0FF);

    // Two back-to-back loads with req_valid held high throughout.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h00001010;
    @(posedge clk);
    #1;
    rsp1 = 0; rsp2 = 0; ready_vec = 8'h0;
    for (int k = 1; k <= 8; k++) begin
      ready_vec[k-1] = req_ready;
      if (rsp_valid) begin
        if (rsp1 == 0) rsp1 = k; else if (rsp2 == 0) rsp2 = k;
        chk("b2b.rdata", rsp_rdata, ref_mem[4]);
      end
      if (k == 5) req_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("b2b.rsp1", 32'(rsp1), 32'd3);
    chk("b2b.rsp2", 32'(rsp2), 32'd7);
    chk("b2b.ready", 32'(ready_vec), 32'h88);

    // Reset asserted while a byte store sits in DATA.
    saved = ref_mem[4];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h010; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid.ready", 32'(req_ready), 32'd1);
    chk("mid.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid.rsp_rdata", rsp_rdata, 32'd0);
    chk("mid.mem_we", 32'(mem_we), 32'd0);
    chk("mid.mem_addr", 32'(mem_addr), 32'd0);
    chk("mid.mem_wdata", mem_wdata, 32'd0);
    mon_we = 0; mon_rsp = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
      if (mem_we) mon_we++;
      if (rsp_valid) mon_rsp++;
    end
    chk("mid.no_we", 32'(mon_we), 32'd0);
    chk("mid.no_rsp", 32'(mon_rsp), 32'd0);
    chk("mid.ram", ram[4], saved);
    do_req(1'b0, 2, 1'b0, 32'h010, 32'h0, "post_rst");

    do_req(1'b0, 2, 1'b0, 32'h011, 32'h0, "misal");

    for (int i = 0; i < 300; i++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[31:4] = 28'(i % 3);
      do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             addr, $urandom, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
